// File: rtl/systolic_acc_drain_if.sv
// Handshake bundle between the systolic multiplier, the accumulate/drain stage
// and the narrow output pins.
interface systolic_acc_drain_if #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned OUT_W  = 8
);
   logic              prod_valid;
   logic [PROD_W-1:0] prod_data;
   logic              prod_last;
   logic              prod_ready;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;
   logic              out_ovf;
   logic              out_ready;

   // Environment side: feeds products, consumes bytes.
   modport master (
      output prod_valid, prod_data, prod_last, out_ready,
      input  prod_ready, out_valid, out_data, out_last, out_ovf
   );

   // Accumulate/drain stage side.
   modport slave (
      input  prod_valid, prod_data, prod_last, out_ready,
      output prod_ready, out_valid, out_data, out_last, out_ovf
   );
endinterface

// File: rtl/systolic_acc_drain.sv
// Accumulates multiplier products into a dot-product sum and drains each finished
// sum LSB-first over a narrow valid/ready byte bus, flagging sums that wrapped.
module systolic_acc_drain #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned OUT_W  = 8
) (
   input logic               clk,
   input logic               reset,
   systolic_acc_drain_if.slave bus
);
   localparam int unsigned NBYTES = ACC_W / OUT_W;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned SUM_W  = ACC_W + 1;

   typedef enum logic {ACC, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               out_ovf_q, out_ovf_d;
   logic               out_last_q, out_last_d;
   logic               prod_ready_q, out_valid_q;
   logic [SUM_W-1:0]   sum_c;

   // One extra bit on the adder exposes the carry out of the accumulator.
   assign sum_c = {1'b0, acc_q} + SUM_W'(bus.prod_data);

   always_ff @(posedge clk) begin
      if (reset) state_q <= ACC;
      else       state_q <= state_d;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      out_ovf_d  = out_ovf_q;
      out_last_d = out_last_q;
      case (state_q)
         ACC: begin
            if (bus.prod_valid) begin
               if (bus.prod_last) begin
                  sreg_d     = sum_c[ACC_W-1:0];
                  out_ovf_d  = ovf_q | sum_c[ACC_W];
                  acc_d      = '0;
                  ovf_d      = 1'b0;
                  cnt_d      = CNT_W'(NBYTES - 1);
                  out_last_d = (NBYTES == 1);
                  state_d    = DRAIN;
               end else begin
                  acc_d = sum_c[ACC_W-1:0];
                  ovf_d = ovf_q | sum_c[ACC_W];
               end
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               sreg_d = sreg_q >> OUT_W;
               if (out_last_q) begin
                  cnt_d      = '0;
                  out_ovf_d  = 1'b0;
                  out_last_d = 1'b0;
                  state_d    = ACC;
               end else begin
                  cnt_d      = cnt_q - CNT_W'(1);
                  out_last_d = (cnt_q == CNT_W'(1));
               end
            end
         end
         default: state_d = ACC;
      endcase
   end

   // Handshake flags are registered copies of the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= '0;
         ovf_q        <= 1'b0;
         sreg_q       <= '0;
         cnt_q        <= '0;
         out_ovf_q    <= 1'b0;
         out_last_q   <= 1'b0;
         prod_ready_q <= 1'b1;
         out_valid_q  <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
         sreg_q       <= sreg_d;
         cnt_q        <= cnt_d;
         out_ovf_q    <= out_ovf_d;
         out_last_q   <= out_last_d;
         prod_ready_q <= (state_d == ACC);
         out_valid_q  <= (state_d == DRAIN);
      end
   end

   assign bus.prod_ready = prod_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = sreg_q[OUT_W-1:0];
   assign bus.out_last   = out_last_q;
   assign bus.out_ovf    = out_ovf_q;
endmodule

// File: tb/tb_systolic_acc_drain.sv
// Bench for systolic_acc_drain: full-precision sum model with a byte queue,
// per-cycle output comparison, and literal checks on captured bytes.
module tb_systolic_acc_drain;
   localparam int unsigned PROD_W = 16;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned OUT_W  = 8;
   localparam int unsigned NBYTES = ACC_W / OUT_W;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       o;
   } byte_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   systolic_acc_drain_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

   systolic_acc_drain #(.PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   longint unsigned m_sum   = 0;
   bit              started = 0;
   byte_t           expq[$];
   byte_t           gotq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Compare against the model, then advance the model by what the next edge does.
   always @(negedge clk) begin
      bit dr;
      longint unsigned s;
      dr = (expq.size() != 0);
      if (started) begin
         chk("out_valid", 32'(bus.out_valid), 32'(dr));
         chk("prod_ready", 32'(bus.prod_ready), 32'(!dr));
         if (dr) begin
            chk("out_data", 32'(bus.out_data), 32'(expq[0].d));
            chk("out_last", 32'(bus.out_last), 32'(expq[0].l));
            chk("out_ovf",  32'(bus.out_ovf),  32'(expq[0].o));
         end
      end
      if (reset) begin
         m_sum = 0;
         expq.delete();
         started = 1;
      end else if (started) begin
         if (dr && bus.out_ready) begin
            void'(expq.pop_front());
            gotq.push_back('{d: bus.out_data, l: bus.out_last, o: bus.out_ovf});
         end else if (!dr && bus.prod_valid) begin
            m_sum += longint'(bus.prod_data);
            if (bus.prod_last) begin
               s = m_sum % (64'd1 << ACC_W);
               for (int i = 0; i < int'(NBYTES); i++)
                  expq.push_back('{d: 8'((s >> (8 * i)) & 64'hFF),
                                   l: (i == int'(NBYTES) - 1),
                                   o: (m_sum >= (64'd1 << ACC_W))});
               m_sum = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] d, input logic l);
      bit acc;
      int n;
      bus.prod_valid = 1'b1;
      bus.prod_data  = d;
      bus.prod_last  = l;
      acc = 0;
      n = 0;
      while (!acc && n < 64) begin
         @(negedge clk);
         acc = bus.prod_ready;
         tick();
         n++;
      end
      if (!acc) chk("beat_timeout", 32'(0), 32'(1));
      bus.prod_valid = 1'b0;
   endtask

   task automatic wait_got(input int cnt);
      int n;
      n = 0;
      while (gotq.size() < cnt && n < 300) begin
         tick();
         n++;
      end
      if (gotq.size() < cnt) chk("drain_timeout", 32'(gotq.size()), 32'(cnt));
   endtask

   task automatic chk_byte(input string nm, input int idx, input logic [7:0] d,
                           input logic l, input logic o);
      if (idx >= gotq.size()) begin
         chk({nm, "_missing"}, 32'(gotq.size()), 32'(idx + 1));
      end else begin
         chk({nm, "_data"}, 32'(gotq[idx].d), 32'(d));
         chk({nm, "_last"}, 32'(gotq[idx].l), 32'(l));
         chk({nm, "_ovf"},  32'(gotq[idx].o), 32'(o));
      end
   endtask

   initial begin
      int n;
      reset          = 1'b1;
      bus.prod_valid = 1'b0;
      bus.prod_data  = '0;
      bus.prod_last  = 1'b0;
      bus.out_ready  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_prod_ready", 32'(bus.prod_ready), 32'(1));
      chk("rst_out_data", 32'(bus.out_data), 32'(0));
      chk("rst_out_last", 32'(bus.out_last), 32'(0));
      chk("rst_out_ovf", 32'(bus.out_ovf), 32'(0));
      tick();

      // Single beat
      gotq.delete();
      beat(16'h1234, 1'b1);
      wait_got(3);
      chk_byte("single_b0", 0, 8'h34, 1'b0, 1'b0);
      chk_byte("single_b1", 1, 8'h12, 1'b0, 1'b0);
      chk_byte("single_b2", 2, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      chk("single_ready_back", 32'(bus.prod_ready), 32'(1));
      tick();

      // Four beats with a gap
      gotq.delete();
      beat(16'hFFFF, 1'b0);
      beat(16'hFFFF, 1'b0);
      tick();
      tick();
      beat(16'hFFFF, 1'b0);
      beat(16'hFFFF, 1'b1);
      wait_got(3);
      chk_byte("four_b0", 0, 8'hFC, 1'b0, 1'b0);
      chk_byte("four_b1", 1, 8'hFF, 1'b0, 1'b0);
      chk_byte("four_b2", 2, 8'h03, 1'b1, 1'b0);

      // Overflow, then a clean sum
      gotq.delete();
      for (int i = 0; i < 257; i++) beat(16'hFFFF, (i == 256));
      wait_got(3);
      chk_byte("ovf_b0", 0, 8'hFF, 1'b0, 1'b1);
      chk_byte("ovf_b1", 1, 8'hFE, 1'b0, 1'b1);
      chk_byte("ovf_b2", 2, 8'h00, 1'b1, 1'b1);
      beat(16'h0001, 1'b1);
      wait_got(6);
      chk_byte("post_ovf_b0", 3, 8'h01, 1'b0, 1'b0);
      chk_byte("post_ovf_b2", 5, 8'h00, 1'b1, 1'b0);

      // Backpressure with a product held on the input
      gotq.delete();
      bus.out_ready = 1'b0;
      beat(16'h1234, 1'b1);
      bus.prod_valid = 1'b1;
      bus.prod_data  = 16'h5555;
      bus.prod_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_data", 32'(bus.out_data), 32'h34);
         chk("bp_prod_ready", 32'(bus.prod_ready), 32'(0));
         tick();
      end
      bus.prod_valid = 1'b0;
      bus.out_ready  = 1'b1;
      wait_got(3);
      chk_byte("bp_b0", 0, 8'h34, 1'b0, 1'b0);
      chk_byte("bp_b1", 1, 8'h12, 1'b0, 1'b0);
      beat(16'h0001, 1'b1);
      wait_got(6);
      chk_byte("bp_next_b0", 3, 8'h01, 1'b0, 1'b0);
      chk_byte("bp_next_b1", 4, 8'h00, 1'b0, 1'b0);

      // Reset in the middle of a drain
      gotq.delete();
      beat(16'h0ABC, 1'b1);
      wait_got(1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("mid_rst_prod_ready", 32'(bus.prod_ready), 32'(1));
      tick();
      gotq.delete();
      beat(16'h0001, 1'b1);
      wait_got(3);
      chk_byte("mid_rst_b0", 0, 8'h01, 1'b0, 1'b0);
      chk_byte("mid_rst_b1", 1, 8'h00, 1'b0, 1'b0);
      chk_byte("mid_rst_b2", 2, 8'h00, 1'b1, 1'b0);

      // Back-to-back sums, second sum's beats held during the first drain
      gotq.delete();
      beat(16'h0010, 1'b1);
      beat(16'h0020, 1'b0);
      beat(16'h0030, 1'b1);
      wait_got(6);
      chk_byte("b2b_b0", 0, 8'h10, 1'b0, 1'b0);
      chk_byte("b2b_b2", 2, 8'h00, 1'b1, 1'b0);
      chk_byte("b2b_b3", 3, 8'h50, 1'b0, 1'b0);
      chk_byte("b2b_b5", 5, 8'h00, 1'b1, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bus.prod_valid = ($urandom_range(0, 9) < 7);
         bus.prod_data  = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
         bus.prod_last  = ($urandom_range(0, 199) == 0) || ($urandom_range(0, 7) == 0 && i < 1000);
         bus.out_ready  = ($urandom_range(0, 9) < 7);
         reset          = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset          = 1'b0;
      bus.prod_valid = 1'b0;
      bus.out_ready  = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("final_drain_empty", 32'(expq.size()), 32'(0));
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
